// File: rtl/clic_gw_pkg.sv
// Shared definitions for the CLIC interrupt gateway: trigger-mode encoding
// and the claim id width helper.
package clic_gw_pkg;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } trig_mode_e;

  // Claim id width; a single source still needs a one-bit id port.
  function automatic int src_width(input int n_source);
    return (n_source > 1) ? $clog2(n_source) : 1;
  endfunction

endpackage

// File: rtl/clic_gw_cell.sv
// One interrupt source: input synchronizer, rise detector and the pending
// bit with its edge/level next-state rules.
module clic_gw_cell
  import clic_gw_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic sw_we,
  input  logic sw_wd,
  input  logic claim_hit,
  output logic pending
);

  logic s;
  logic prev_q;
  logic rise;
  logic pend_d;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s = src;
    end
  endgenerate

  // prev tracks s in both modes, so switching mode never fabricates a rise.
  assign rise = s & ~prev_q;

  always_comb begin
    pend_d = pending;
    if (mode == EDGE) begin
      if (rise) begin
        pend_d = 1'b1;
      end else if (sw_we) begin
        pend_d = sw_wd;
      end else if (claim_hit) begin
        pend_d = 1'b0;
      end
    end else begin
      pend_d = s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev_q  <= s;
      pending <= pend_d;
    end
  end

endmodule

// File: rtl/clic_gateway.sv
// CLIC interrupt gateway: per-source pending cells plus the shared claim
// decoder, claim handshake and out-of-range claim error pulse.
module clic_gateway
  import clic_gw_pkg::*;
#(
  parameter  int N_SOURCE    = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int SRC_W       = src_width(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] ip_sw_we_i,
  input  logic [N_SOURCE-1:0] ip_sw_wd_i,
  input  logic                claim_valid_i,
  input  logic [SRC_W-1:0]    claim_id_i,
  output logic                claim_ready_o,
  output logic                claim_err_o,
  output logic [N_SOURCE-1:0] ip_o
);

  logic                arm_q;
  logic                ready_q;
  logic                err_q;
  logic [31:0]         id_ext;
  logic                in_range;
  logic                accept;
  logic [N_SOURCE-1:0] claim_hit;

  assign id_ext   = 32'(claim_id_i);
  assign in_range = (id_ext < 32'(N_SOURCE));
  assign accept   = claim_valid_i & ready_q;

  // Ready comes up on the second edge after reset release, giving the
  // synchronizers one full cycle before claims are honoured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arm_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      arm_q   <= 1'b1;
      ready_q <= arm_q;
      err_q   <= accept & ~in_range;
    end
  end

  assign claim_ready_o = ready_q;
  assign claim_err_o   = err_q;

  generate
    for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
      assign claim_hit[i] = accept & in_range & (id_ext == 32'(i));

      clic_gw_cell #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_cell (
        .clk       (clk_i),
        .rst       (rst_i),
        .src       (intr_src_i[i]),
        .mode      (le_i[i]),
        .sw_we     (ip_sw_we_i[i]),
        .sw_wd     (ip_sw_wd_i[i]),
        .claim_hit (claim_hit[i]),
        .pending   (ip_o[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clic_gateway.sv
// Directed and randomized checks of clic_gateway against a cycle-level
// behavioural model of the pending-bit rules.
module tb_clic_gateway;

  localparam int N  = 20;
  localparam int SS = 2;
  localparam int W  = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] intr, le, we, wd;
  logic         cv;
  logic [W-1:0] cid;
  logic         crdy, cerr;
  logic [N-1:0] ip;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: hist[0] is the newest sampled input vector.
  logic [N-1:0] hist [SS+1];
  logic [N-1:0] m_pend;
  logic         m_err;
  int           m_edges;
  logic [N-1:0] snap;

  clic_gateway #(
    .N_SOURCE    (N),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .intr_src_i    (intr),
    .le_i          (le),
    .ip_sw_we_i    (we),
    .ip_sw_wd_i    (wd),
    .claim_valid_i (cv),
    .claim_id_i    (cid),
    .claim_ready_o (crdy),
    .claim_err_o   (cerr),
    .ip_o          (ip)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= SS; k++) hist[k] = '0;
    m_pend  = '0;
    m_err   = 1'b0;
    m_edges = 0;
  endtask

  // One rising edge of the spec's behaviour, evaluated from the inputs
  // present just before the edge.
  task automatic model_edge();
    logic [N-1:0] s, pv, rise;
    logic acc;
    if (rst) return;
    s    = hist[SS-1];
    pv   = hist[SS];
    rise = s & ~pv;
    acc  = cv && (m_edges >= 2);
    for (int i = 0; i < N; i++) begin
      if (le[i]) begin
        if (rise[i]) m_pend[i] = 1'b1;
        else if (we[i]) m_pend[i] = wd[i];
        else if (acc && (int'(cid) == i)) m_pend[i] = 1'b0;
      end else begin
        m_pend[i] = s[i];
      end
    end
    m_err = acc && (int'(cid) >= N);
    for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = intr;
    if (m_edges < 2) m_edges++;
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput({tag, ":ip"},    32'(ip),   32'(m_pend));
    checkOutput({tag, ":err"},   32'(cerr), 32'(m_err));
    checkOutput({tag, ":ready"}, 32'(crdy), 32'(m_edges >= 2));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("rst:ip",    32'(ip),   32'd0);
    checkOutput("rst:ready", 32'(crdy), 32'd0);
    checkOutput("rst:err",   32'(cerr), 32'd0);
    applyStimulus("in_rst");
    applyStimulus("in_rst");
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    intr = '0;
    le   = '1;
    le[2] = 1'b0;
    we   = '0;
    wd   = '0;
    cv   = 1'b0;
    cid  = '0;
    model_reset();
    #1;
    apply_reset();

    applyStimulus("rel1");
    checkOutput("ready_first", 32'(crdy), 32'd0);
    applyStimulus("rel2");
    checkOutput("ready_up", 32'(crdy), 32'd1);

    // Edge latency and single set while held
    intr[3] = 1'b1;
    applyStimulus("lat");
    checkOutput("lat_e1", 32'(ip[3]), 32'd0);
    applyStimulus("lat");
    checkOutput("lat_e2", 32'(ip[3]), 32'd0);
    applyStimulus("lat");
    checkOutput("lat_e3", 32'(ip[3]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("hold");
      checkOutput("hold_ip3", 32'(ip[3]), 32'd1);
    end
    cv = 1'b1; cid = W'(3);
    applyStimulus("clr_held");
    cv = 1'b0;
    checkOutput("clr_held_ip3", 32'(ip[3]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("no_reset");
      checkOutput("no_second_set", 32'(ip[3]), 32'd0);
    end

    // Claim clears only the claimed source
    we[3] = 1'b1; wd[3] = 1'b1; we[5] = 1'b1; wd[5] = 1'b1;
    applyStimulus("swset");
    we = '0; wd = '0;
    checkOutput("swset_ip3", 32'(ip[3]), 32'd1);
    checkOutput("swset_ip5", 32'(ip[5]), 32'd1);
    cv = 1'b1; cid = W'(3);
    applyStimulus("claim3");
    cv = 1'b0;
    checkOutput("claim3_ip3", 32'(ip[3]), 32'd0);
    checkOutput("claim3_ip5", 32'(ip[5]), 32'd1);
    intr[3] = 1'b0;

    // Edge beats a simultaneous claim and a simultaneous software clear
    we[7] = 1'b1; wd[7] = 1'b1;
    applyStimulus("set7");
    we = '0; wd = '0;
    intr[7] = 1'b1;
    applyStimulus("e7");
    applyStimulus("e7");
    cv = 1'b1; cid = W'(7);
    applyStimulus("edge_vs_claim");
    cv = 1'b0;
    checkOutput("edge_vs_claim_ip7", 32'(ip[7]), 32'd1);
    intr[7] = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus("fall7");
    checkOutput("fall7_hold", 32'(ip[7]), 32'd1);
    cv = 1'b1; cid = W'(7);
    applyStimulus("claim7");
    cv = 1'b0;
    checkOutput("claim7_ip7", 32'(ip[7]), 32'd0);
    intr[7] = 1'b1;
    applyStimulus("e7b");
    applyStimulus("e7b");
    checkOutput("e7b_pre", 32'(ip[7]), 32'd0);
    we[7] = 1'b1; wd[7] = 1'b0;
    applyStimulus("edge_vs_sw");
    we = '0;
    checkOutput("edge_vs_sw_ip7", 32'(ip[7]), 32'd1);

    // Level mode follows the source, delayed, and ignores claims
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) intr[2] = 1'b1;
      if (k == 6) intr[2] = 1'b0;
      cv  = (k == 5);
      cid = W'(2);
      applyStimulus("level");
      checkOutput($sformatf("level_k%0d", k), 32'(ip[2]), 32'((k >= 3) && (k <= 7)));
      checkOutput("level_err", 32'(cerr), 32'd0);
    end
    cv = 1'b0;

    // Out-of-range claim
    snap = m_pend;
    cv = 1'b1; cid = W'(25);
    applyStimulus("bad");
    cv = 1'b0;
    checkOutput("bad_err", 32'(cerr), 32'd1);
    checkOutput("bad_ip", 32'(ip), 32'(snap));
    applyStimulus("bad_after");
    checkOutput("bad_err_pulse", 32'(cerr), 32'd0);

    // Level -> edge change keeps pending and invents no edge
    le[9] = 1'b0; intr[9] = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus("lvl9");
    checkOutput("lvl9_ip", 32'(ip[9]), 32'd1);
    le[9] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus("mode9");
      checkOutput("mode9_keep", 32'(ip[9]), 32'd1);
    end
    cv = 1'b1; cid = W'(9);
    applyStimulus("claim9");
    cv = 1'b0;
    checkOutput("claim9_ip", 32'(ip[9]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("mode9_quiet");
      checkOutput("mode9_no_edge", 32'(ip[9]), 32'd0);
    end

    // Mid-operation reset with a source held high
    intr = '0;
    intr[0] = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus("pre_rst");
    checkOutput("pre_rst_ip0", 32'(ip[0]), 32'd1);
    apply_reset();
    applyStimulus("post1");
    checkOutput("post1_ip0", 32'(ip[0]), 32'd0);
    checkOutput("post1_ready", 32'(crdy), 32'd0);
    applyStimulus("post2");
    checkOutput("post2_ip0", 32'(ip[0]), 32'd0);
    applyStimulus("post3");
    checkOutput("post3_ip0", 32'(ip[0]), 32'd1);
    applyStimulus("post4");
    checkOutput("post4_ip0", 32'(ip[0]), 32'd1);

    // Randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      intr ^= N'($urandom & $urandom & $urandom);
      le   ^= N'($urandom & $urandom & $urandom & $urandom);
      we   = N'($urandom & $urandom & $urandom);
      wd   = N'($urandom);
      cv   = 1'($urandom_range(0, 1));
      cid  = W'($urandom_range(0, 31));
      applyStimulus("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/clic_gateway.md
CLIC_GATEWAY -- requirements
Module: clic_gateway

Interface
REQ-001 SHALL have parameter N_SOURCE, default 32, number of interrupt sources.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per source; 0 means no synchronizer.
REQ-003 SHALL have localparam SRC_W = max(1, clog2(N_SOURCE)), claim id width.
REQ-004 SHALL have ports, in this order:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- intr_src_i  input  N_SOURCE  raw interrupt lines, possibly asynchronous.
- le_i  input  N_SOURCE  trigger mode per source: 1 = positive edge, 0 = positive level.
- ip_sw_we_i  input  N_SOURCE  software write strobe to the pending bit.
- ip_sw_wd_i  input  N_SOURCE  software write data to the pending bit.
- claim_valid_i  input  1  core claims an interrupt this cycle.
- claim_id_i  input  SRC_W  id of the claimed source.
- claim_ready_o  output  1  claim accepted.
- claim_err_o  output  1  one-cycle pulse on an out-of-range claim.
- ip_o  output  N_SOURCE  pending bits; drives the register adapter's ip input, which writes them every cycle.

Function
REQ-005 SHALL pass each intr_src_i bit through SYNC_STAGES flops to give s[i]; with SYNC_STAGES=0, s[i] = intr_src_i[i].
REQ-006 SHALL register prev[i] <= s[i] every cycle, in both modes.
REQ-007 SHALL detect edge[i] = s[i] & ~prev[i].
REQ-008 In edge mode (le_i[i]=1), next pending[i] SHALL use this priority: edge[i] -> 1; else ip_sw_we_i[i] -> ip_sw_wd_i[i]; else claim hit on i -> 0; else hold.
REQ-009 In level mode (le_i[i]=0), pending[i] SHALL load s[i] every cycle; software writes and claims SHALL be ignored.
REQ-010 ip_o SHALL equal pending registered, with no combinational path from any input.
REQ-011 Latency SHALL be exactly SYNC_STAGES+1 rising edges from intr_src_i sampled high to ip_o high, in both modes.
REQ-012 A claim hit SHALL be claim_valid_i & claim_ready_o & (claim_id_i < N_SOURCE) & (claim_id_i == i).
REQ-013 claim_ready_o SHALL be 0 during reset and in the first cycle after reset release, and 1 thereafter.
REQ-014 An accepted claim with claim_id_i >= N_SOURCE SHALL leave all pending bits unchanged and pulse claim_err_o high for the following cycle.
REQ-015 An edge arriving in the same cycle as a claim of that source SHALL leave pending = 1; the new edge is not lost.
REQ-016 A mode change on le_i SHALL NOT create a spurious edge. Pending SHALL keep its value on a level->edge change until a set or clear event.
REQ-017 A source held high SHALL produce exactly one edge.
REQ-018 A claim of a source in level mode SHALL set no error and change nothing.

Reset
REQ-019 Asserting rst_i SHALL immediately clear all synchronizer flops, prev, pending (ip_o = 0), claim_err_o = 0 and claim_ready_o = 0.
REQ-020 A source already high when reset is released SHALL produce one edge, because prev resets to 0.
REQ-021 Reset asserted mid-operation SHALL discard all pending and in-flight edges; none SHALL reappear after release unless the source is still high (REQ-020).

Structure
REQ-022 SRC_W computation and the trigger-mode encoding constants (EDGE=1, LEVEL=0) SHALL live in a shared package clic_gw_pkg.
REQ-023 Per-source logic (synchronizer, prev, pending next-state) SHALL be a sub-module clic_gw_cell, instantiated N_SOURCE times.
REQ-024 Claim decode and claim_err_o SHALL stay in the top module.

Verification
REQ-025 Edge latency: SYNC_STAGES=2, le=1, src[3] 0->1 held -> ip_o[3] rises exactly 3 edges later, stays 1, and no second set occurs while held.
REQ-026 Claim clear: pending[3]=1, claim_valid=1 with id=3 for one cycle -> ip_o[3]=0 next cycle, while ip_o[5]=1 stays unchanged.
REQ-027 Simultaneous events: new edge on src[7] in the same cycle as a claim with id=7 -> ip_o[7] remains 1; software write wd=0 in the same cycle as an edge -> ip_o[7]=1.
REQ-028 Level mode: le[2]=0, src[2] high for 5 cycles -> ip_o[2] high for exactly 5 cycles, delayed by 3; a claim with id=2 mid-pulse has no effect.
REQ-029 Bad claim: N_SOURCE=20, claim_id=25 -> claim_err_o pulses 1 cycle and ip_o is unchanged.
REQ-030 Reset: rst_i asserted mid-operation with src[0] high -> ip_o=0 immediately; after release, ip_o[0] rises once after 3 edges and claim_ready_o=0 for one cycle.
